// File: rtl/gemm_pkg.sv
// Shared types and defaults for the GEMM result drain.
package gemm_pkg;

  typedef enum logic {IDLE, DRAIN} drain_state_t;

  localparam int unsigned GEMM_DIM      = 16;
  localparam int unsigned GEMM_WIDTH    = 8;
  localparam int unsigned GEMM_OUT_BITS = 2 * GEMM_WIDTH;
  localparam int unsigned ROW_IDX_W     = $clog2(GEMM_DIM);

  function automatic int unsigned sum_w(input int unsigned dim, input int unsigned bits);
    return bits + $clog2(dim);
  endfunction

endpackage

// File: rtl/gemm_row_sum.sv
// Unsigned sum of one result row; width grows by clog2(DIM) so it cannot overflow.
module gemm_row_sum
  import gemm_pkg::*;
#(
  parameter int unsigned DIM      = GEMM_DIM,
  parameter int unsigned OUT_BITS = GEMM_OUT_BITS
) (
  input  logic [DIM-1:0][OUT_BITS-1:0]          row_i,
  output logic [sum_w(DIM, OUT_BITS)-1:0]       sum_o
);

  localparam int unsigned SW = sum_w(DIM, OUT_BITS);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      sum_o = sum_o + SW'(row_i[i]);
    end
  end

endmodule

// File: rtl/gemm_result_drain.sv
// Snapshots the GEMM result matrix on res_valid and streams it out one row per beat.
// Optional row_sum output enabled by defining GEMM_DRAIN_ROWSUM_EN.
module gemm_result_drain
  import gemm_pkg::*;
#(
  parameter int unsigned DIM      = GEMM_DIM,
  parameter int unsigned WIDTH    = GEMM_WIDTH,
  parameter int unsigned OUT_BITS = 2 * WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] res_in,
  input  logic                                  res_valid,
  output logic [DIM-1:0][OUT_BITS-1:0]          row_data,
  output logic [$clog2(DIM)-1:0]                row_idx,
  output logic                                  row_last,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic                                  busy,
  output logic                                  overrun
`ifdef GEMM_DRAIN_ROWSUM_EN
  ,
  output logic [sum_w(DIM, OUT_BITS)-1:0]       row_sum
`endif
);

  localparam int unsigned IW = $clog2(DIM);

  drain_state_t                          state_q;
  logic [IW-1:0]                         row_idx_q;
  logic                                  valid_q;
  logic                                  busy_q;
  logic                                  overrun_q;
  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] buf_q;

  logic final_hs;
  logic capture;

  assign row_last  = valid_q && (row_idx_q == IW'(DIM - 1));
  assign final_hs  = valid_q && row_ready && row_last;
  // A new matrix is accepted when idle or exactly on the last beat of the current one.
  assign capture   = res_valid && ((state_q == IDLE) || final_hs);

  assign row_valid = valid_q;
  assign row_idx   = row_idx_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign row_data  = buf_q[row_idx_q];

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= res_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (res_valid) begin
            state_q   <= DRAIN;
            row_idx_q <= '0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        DRAIN: begin
          if (valid_q && row_ready) begin
            if (row_last) begin
              row_idx_q <= '0;
              if (!res_valid) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else begin
              row_idx_q <= row_idx_q + IW'(1);
            end
          end
          if (res_valid && !final_hs) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GEMM_DRAIN_ROWSUM_EN
  logic [sum_w(DIM, OUT_BITS)-1:0] sum_raw;

  gemm_row_sum #(
    .DIM      (DIM),
    .OUT_BITS (OUT_BITS)
  ) u_row_sum (
    .row_i (row_data),
    .sum_o (sum_raw)
  );

  assign row_sum = valid_q ? sum_raw : '0;
`endif

endmodule

// File: tb/tb_gemm_result_drain.sv
// Directed bench for gemm_result_drain at DIM=4, OUT_BITS=16.
module tb_gemm_result_drain;

  localparam int D = 4;
  localparam int B = 16;

  typedef logic [D-1:0][B-1:0] row_t;

  logic                        clk;
  logic                        reset_n;
  logic [D-1:0][D-1:0][B-1:0]  res_in;
  logic                        res_valid;
  row_t                        row_data;
  logic [1:0]                  row_idx;
  logic                        row_last;
  logic                        row_valid;
  logic                        row_ready;
  logic                        busy;
  logic                        overrun;
`ifdef GEMM_DRAIN_ROWSUM_EN
  logic [17:0]                 row_sum;
`endif

  int checks = 0;
  int errors = 0;

  gemm_result_drain #(
    .DIM      (D),
    .WIDTH    (8),
    .OUT_BITS (B)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .res_in    (res_in),
    .res_valid (res_valid),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .busy      (busy),
    .overrun   (overrun)
`ifdef GEMM_DRAIN_ROWSUM_EN
    ,
    .row_sum   (row_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        res_in[r][c] = B'(base + 16 * r + c);
  endtask

  function automatic row_t mkrow(input int base, input int r);
    row_t v;
    for (int c = 0; c < D; c++) v[c] = B'(base + 16 * r + c);
    return v;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; res_valid = 1'b0; row_ready = 1'b0; res_in = '0;
    #12;
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || row_idx !== 2'd0 || row_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b ovr=%b idx=%0d last=%b, required all 0", row_valid, busy, overrun, row_idx, row_last);
    end
    #1 reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    load(0); res_valid = 1'b1; row_ready = 1'b1;
    step();
    res_valid = 1'b0;
    for (int r = 0; r < D; r++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(r) || row_data !== mkrow(0, r) ||
          row_last !== (r == D - 1) || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic row%0d: valid=%b idx=%0d last=%b busy=%b data=%h, required data=%h", r, row_valid, row_idx, row_last, busy, row_data, mkrow(0, r));
      end
      step();
    end
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || row_last !== 1'b0) begin
      errors++;
      $display("FAIL basic end: valid=%b busy=%b last=%b, required 0 0 0", row_valid, busy, row_last);
    end
  endtask

  task automatic test_backpressure();
    int n, held;
    n = 0; held = 0;
    load(0); res_valid = 1'b1; row_ready = 1'b1;
    step();
    res_valid = 1'b0;
    while (row_valid === 1'b1 && n < 20) begin
      if (row_idx === 2'd1 && held < 3) begin
        row_ready = 1'b0;
        held++;
        checks++;
        if (row_data !== mkrow(0, 1) || row_last !== 1'b0) begin
          errors++;
          $display("FAIL backpressure hold%0d: data=%h last=%b, required %h 0", held, row_data, row_last, mkrow(0, 1));
        end
      end else begin
        row_ready = 1'b1;
      end
      step();
      n++;
    end
    row_ready = 1'b1;
    checks++;
    if (n !== 7 || held !== 3) begin
      errors++;
      $display("FAIL backpressure drain: cycles=%0d held=%0d, required 7 3", n, held);
    end
  endtask

  task automatic test_back_to_back();
    load(0); res_valid = 1'b1; row_ready = 1'b1;
    step();
    res_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (row_idx !== 2'd3 || row_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b pre: idx=%0d last=%b, required 3 1", row_idx, row_last);
    end
    load(100); res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    for (int r = 0; r < D; r++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(r) || row_data !== mkrow(100, r) || overrun !== 1'b0) begin
        errors++;
        $display("FAIL b2b row%0d: valid=%b idx=%0d ovr=%b data=%h, required data=%h", r, row_valid, row_idx, overrun, row_data, mkrow(100, r));
      end
      step();
    end
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b end: valid=%b busy=%b, required 0 0", row_valid, busy);
    end
  endtask

  task automatic test_overrun();
    load(200); res_valid = 1'b1; row_ready = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    row_ready = 1'b0;
    load(300); res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (overrun !== 1'b1 || row_idx !== 2'd1 || row_data !== mkrow(200, 1)) begin
        errors++;
        $display("FAIL overrun hold%0d: ovr=%b idx=%0d data=%h, required 1 1 %h", k, overrun, row_idx, row_data, mkrow(200, 1));
      end
      step();
    end
    row_ready = 1'b1;
    for (int r = 1; r < D; r++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(r) || row_data !== mkrow(200, r)) begin
        errors++;
        $display("FAIL overrun row%0d: valid=%b idx=%0d data=%h, required %h", r, row_valid, row_idx, row_data, mkrow(200, r));
      end
      step();
    end
    checks++;
    if (row_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun sticky: valid=%b ovr=%b, required 0 1", row_valid, overrun);
    end
  endtask

  task automatic test_reset_mid();
    load(0); res_valid = 1'b1; row_ready = 1'b1;
    step();
    res_valid = 1'b0;
    step(); step();
    checks++;
    if (row_idx !== 2'd2) begin
      errors++;
      $display("FAIL rstmid pre: idx=%0d, required 2", row_idx);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || row_idx !== 2'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid async: valid=%b busy=%b idx=%0d ovr=%b, required 0 0 0 0", row_valid, busy, row_idx, overrun);
    end
    #1 reset_n = 1'b1;
    step();
    load(50); res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    checks++;
    if (row_valid !== 1'b1 || row_idx !== 2'd0 || row_data !== mkrow(50, 0)) begin
      errors++;
      $display("FAIL rstmid recapture: valid=%b idx=%0d data=%h, required 1 0 %h", row_valid, row_idx, row_data, mkrow(50, 0));
    end
    step(); step(); step(); step();
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid end: valid=%b busy=%b, required 0 0", row_valid, busy);
    end
  endtask

`ifdef GEMM_DRAIN_ROWSUM_EN
  task automatic test_rowsum();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        res_in[r][c] = 16'hFFFF;
    res_valid = 1'b1; row_ready = 1'b1;
    step();
    res_valid = 1'b0;
    for (int r = 0; r < D; r++) begin
      checks++;
      if (row_sum !== 18'h3FFFC) begin
        errors++;
        $display("FAIL rowsum row%0d: got %h, required 3fffc", r, row_sum);
      end
      step();
    end
    checks++;
    if (row_sum !== 18'h0) begin
      errors++;
      $display("FAIL rowsum idle: got %h, required 0", row_sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef GEMM_DRAIN_ROWSUM_EN
    test_rowsum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
